// File: rtl/core_axi_pkg.sv
// Shared AXI encodings, bridge state and in-flight tracker entry for core_axi_bridge.
package core_axi_pkg;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // Lane select wide enough for the widest (128-bit) AXI data bus.
   localparam int unsigned TRK_LANE_W = 2;

   typedef enum logic {
      IDLE,
      WR_PEND
   } bridge_state_e;

   typedef struct packed {
      logic                  we;
      logic [TRK_LANE_W-1:0] lane;
   } trk_entry_t;

   function automatic logic [TRK_LANE_W-1:0] lane_of(input logic [1:0] word_sel,
                                                     input int unsigned lanes);
      if (lanes > 1) return word_sel & TRK_LANE_W'(lanes - 1);
      return '0;
   endfunction

   function automatic logic resp_is_err(input logic [1:0] resp);
      logic err;
      case (resp)
         AXI_RESP_OKAY, AXI_RESP_EXOKAY:  err = 1'b0;
         AXI_RESP_SLVERR, AXI_RESP_DECERR: err = 1'b1;
         default:                         err = 1'b0;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/core_axi_bridge_fifo.sv
// In-order tracker of issued transactions; push and pop may coincide, including at full.
module core_axi_bridge_fifo
   import core_axi_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push_i,
   input  trk_entry_t din_i,
   input  logic       pop_i,
   output trk_entry_t dout_o,
   output logic       empty_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   trk_entry_t             mem_q [DEPTH];
   trk_entry_t             mem_d [DEPTH];
   logic       [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic       [CNT_W-1:0] count_q, count_d;
   logic                   full, do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign dout_o  = mem_q[rptr_q];

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      do_pop  = pop_i & ~empty_o;
      do_push = push_i & (~full | do_pop);
      if (do_push) begin
         mem_d[wptr_q] = din_i;
         wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/core_axi_bridge.sv
// Pipelined core data-port to AXI4 master bridge, responses returned in issue order.
// Optional CORE_AXI_BRIDGE_RSP_REG_EN registers the core response outputs (+1 cycle).
module core_axi_bridge
   import core_axi_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned ID_WIDTH        = 16,
   parameter int unsigned USER_WIDTH      = 10,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    data_req_i,
   output logic                    data_gnt_o,
   output logic                    data_rvalid_o,
   output logic                    data_err_o,
   input  logic [ADDR_WIDTH-1:0]   data_addr_i,
   input  logic                    data_we_i,
   input  logic [3:0]              data_be_i,
   input  logic [31:0]             data_wdata_i,
   output logic [31:0]             data_rdata_o,
   output logic [ID_WIDTH-1:0]     aw_id_o,
   output logic [ADDR_WIDTH-1:0]   aw_addr_o,
   output logic [7:0]              aw_len_o,
   output logic [2:0]              aw_size_o,
   output logic [1:0]              aw_burst_o,
   output logic                    aw_lock_o,
   output logic [3:0]              aw_cache_o,
   output logic [2:0]              aw_prot_o,
   output logic [3:0]              aw_qos_o,
   output logic [3:0]              aw_region_o,
   output logic [USER_WIDTH-1:0]   aw_user_o,
   output logic                    aw_valid_o,
   input  logic                    aw_ready_i,
   output logic [DATA_WIDTH-1:0]   w_data_o,
   output logic [DATA_WIDTH/8-1:0] w_strb_o,
   output logic                    w_last_o,
   output logic [USER_WIDTH-1:0]   w_user_o,
   output logic                    w_valid_o,
   input  logic                    w_ready_i,
   input  logic [ID_WIDTH-1:0]     b_id_i,
   input  logic [1:0]              b_resp_i,
   input  logic [USER_WIDTH-1:0]   b_user_i,
   input  logic                    b_valid_i,
   output logic                    b_ready_o,
   output logic [ID_WIDTH-1:0]     ar_id_o,
   output logic [ADDR_WIDTH-1:0]   ar_addr_o,
   output logic [7:0]              ar_len_o,
   output logic [2:0]              ar_size_o,
   output logic [1:0]              ar_burst_o,
   output logic                    ar_lock_o,
   output logic [3:0]              ar_cache_o,
   output logic [2:0]              ar_prot_o,
   output logic [3:0]              ar_qos_o,
   output logic [3:0]              ar_region_o,
   output logic [USER_WIDTH-1:0]   ar_user_o,
   output logic                    ar_valid_o,
   input  logic                    ar_ready_i,
   input  logic [ID_WIDTH-1:0]     r_id_i,
   input  logic [DATA_WIDTH-1:0]   r_data_i,
   input  logic [1:0]              r_resp_i,
   input  logic                    r_last_i,
   input  logic [USER_WIDTH-1:0]   r_user_i,
   input  logic                    r_valid_i,
   output logic                    r_ready_o
);

   localparam int unsigned LANES  = DATA_WIDTH / 32;
   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);

   bridge_state_e         state_q, state_d;
   logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic                  dir_q, dir_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   trk_entry_t            head, push_entry;
   logic                  trk_empty;
   logic [TRK_LANE_W-1:0] req_lane;
   logic                  accept, rd_act, wr_act, ar_hs, aw_hs, w_hs, aw_fin, w_fin, wr_gnt, gnt;
   logic                  rsp_fire, rsp_err;
   logic [31:0]           rsp_rdata;

   // Single-beat, 32-bit, ID 0 transfers: every attribute field is static.
   assign aw_id_o     = '0;
   assign aw_addr_o   = data_addr_i;
   assign aw_len_o    = 8'd0;
   assign aw_size_o   = AXI_SIZE_4B;
   assign aw_burst_o  = AXI_BURST_INCR;
   assign aw_lock_o   = 1'b0;
   assign aw_cache_o  = 4'd0;
   assign aw_prot_o   = 3'd0;
   assign aw_qos_o    = 4'd0;
   assign aw_region_o = 4'd0;
   assign aw_user_o   = '0;
   assign ar_id_o     = '0;
   assign ar_addr_o   = data_addr_i;
   assign ar_len_o    = 8'd0;
   assign ar_size_o   = AXI_SIZE_4B;
   assign ar_burst_o  = AXI_BURST_INCR;
   assign ar_lock_o   = 1'b0;
   assign ar_cache_o  = 4'd0;
   assign ar_prot_o   = 3'd0;
   assign ar_qos_o    = 4'd0;
   assign ar_region_o = 4'd0;
   assign ar_user_o   = '0;
   assign w_last_o    = 1'b1;
   assign w_user_o    = '0;

   assign req_lane = lane_of(data_addr_i[3:2], LANES);
   assign w_data_o = {LANES{data_wdata_i}};
   assign w_strb_o = STRB_W'(data_be_i) << {req_lane, 2'b00};

   // Only the tracker head's channel is ever ready, so stray beats are never consumed.
   assign r_ready_o = ~trk_empty & ~head.we;
   assign b_ready_o = ~trk_empty &  head.we;
   assign rsp_fire  = (r_valid_i & r_ready_o) | (b_valid_i & b_ready_o);
   assign rsp_err   = head.we ? resp_is_err(b_resp_i) : resp_is_err(r_resp_i);
   assign rsp_rdata = head.we ? 32'd0 : 32'(r_data_i >> {head.lane, 5'd0});

   always_comb begin
      state_d   = state_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      dir_d     = dir_q;
      cnt_d     = cnt_q;
      // A half-finished write owns the port; otherwise need a free slot and no direction change.
      if (state_q == WR_PEND) accept = data_we_i;
      else accept = ((cnt_q < CNT_W'(MAX_OUTSTANDING)) | rsp_fire) &
                    ((cnt_q == '0) | (data_we_i == dir_q));
      rd_act     = data_req_i & ~data_we_i & accept & (state_q == IDLE);
      wr_act     = data_req_i &  data_we_i & accept;
      ar_valid_o = rd_act;
      aw_valid_o = wr_act & ~aw_done_q;
      w_valid_o  = wr_act & ~w_done_q;
      ar_hs      = ar_valid_o & ar_ready_i;
      aw_hs      = aw_valid_o & aw_ready_i;
      w_hs       = w_valid_o & w_ready_i;
      aw_fin     = aw_done_q | aw_hs;
      w_fin      = w_done_q | w_hs;
      wr_gnt     = wr_act & aw_fin & w_fin;
      gnt        = ar_hs | wr_gnt;
      aw_done_d  = aw_fin & ~wr_gnt;
      w_done_d   = w_fin & ~wr_gnt;
      state_d    = (aw_done_d | w_done_d) ? WR_PEND : IDLE;
      if (gnt) dir_d = data_we_i;
      cnt_d      = cnt_q + CNT_W'(gnt) - CNT_W'(rsp_fire);
   end

   assign data_gnt_o = gnt;
   assign push_entry = '{we: data_we_i, lane: req_lane};

   core_axi_bridge_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_trk (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (gnt),
      .din_i   (push_entry),
      .pop_i   (rsp_fire),
      .dout_o  (head),
      .empty_o (trk_empty)
   );

`ifdef CORE_AXI_BRIDGE_RSP_REG_EN
   logic        rvalid_q, rvalid_d, err_q, err_d;
   logic [31:0] rdata_q, rdata_d;

   always_comb begin
      rvalid_d = rsp_fire;
      err_d    = rsp_fire & rsp_err;
      rdata_d  = rdata_q;
      if (rsp_fire) rdata_d = rsp_rdata;
   end

   assign data_rvalid_o = rvalid_q;
   assign data_err_o    = err_q;
   assign data_rdata_o  = rdata_q;
`else
   assign data_rvalid_o = rsp_fire;
   assign data_err_o    = rsp_fire & rsp_err;
   assign data_rdata_o  = rsp_rdata;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         dir_q     <= 1'b0;
         cnt_q     <= '0;
`ifdef CORE_AXI_BRIDGE_RSP_REG_EN
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         dir_q     <= dir_d;
         cnt_q     <= cnt_d;
`ifdef CORE_AXI_BRIDGE_RSP_REG_EN
         rvalid_q  <= rvalid_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
`endif
      end
   end

   logic unused_inputs;
   assign unused_inputs = ^{b_id_i, b_user_i, r_id_i, r_last_i, r_user_i};

endmodule

// File: tb/tb_core_axi_bridge.sv
// Directed bench for core_axi_bridge (64-bit AXI data, 4 outstanding) with a response scoreboard.
`define CHK(t, o, e) chk(t, 128'(o), 128'(e))

module tb_core_axi_bridge;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 64;
   localparam int unsigned IW = 16;
   localparam int unsigned UW = 10;
   localparam int unsigned MO = 4;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   logic          data_req_i, data_gnt_o, data_rvalid_o, data_err_o, data_we_i;
   logic [AW-1:0] data_addr_i;
   logic [3:0]    data_be_i;
   logic [31:0]   data_wdata_i, data_rdata_o;
   logic [IW-1:0] aw_id_o, ar_id_o, b_id_i, r_id_i;
   logic [AW-1:0] aw_addr_o, ar_addr_o;
   logic [7:0]    aw_len_o, ar_len_o;
   logic [2:0]    aw_size_o, ar_size_o, aw_prot_o, ar_prot_o;
   logic [1:0]    aw_burst_o, ar_burst_o, b_resp_i, r_resp_i;
   logic          aw_lock_o, ar_lock_o;
   logic [3:0]    aw_cache_o, ar_cache_o, aw_qos_o, ar_qos_o, aw_region_o, ar_region_o;
   logic [UW-1:0] aw_user_o, ar_user_o, w_user_o, b_user_i, r_user_i;
   logic          aw_valid_o, aw_ready_i, w_last_o, w_valid_o, w_ready_i;
   logic          b_valid_i, b_ready_o, ar_valid_o, ar_ready_i, r_last_i, r_valid_i, r_ready_o;
   logic [DW-1:0] w_data_o, r_data_i;
   logic [DW/8-1:0] w_strb_o;

   core_axi_bridge #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
      .data_err_o(data_err_o), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
      .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
      .aw_id_o(aw_id_o), .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o), .aw_size_o(aw_size_o),
      .aw_burst_o(aw_burst_o), .aw_lock_o(aw_lock_o), .aw_cache_o(aw_cache_o),
      .aw_prot_o(aw_prot_o), .aw_qos_o(aw_qos_o), .aw_region_o(aw_region_o),
      .aw_user_o(aw_user_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
      .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_last_o(w_last_o), .w_user_o(w_user_o),
      .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
      .b_id_i(b_id_i), .b_resp_i(b_resp_i), .b_user_i(b_user_i), .b_valid_i(b_valid_i),
      .b_ready_o(b_ready_o),
      .ar_id_o(ar_id_o), .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o),
      .ar_burst_o(ar_burst_o), .ar_lock_o(ar_lock_o), .ar_cache_o(ar_cache_o),
      .ar_prot_o(ar_prot_o), .ar_qos_o(ar_qos_o), .ar_region_o(ar_region_o),
      .ar_user_o(ar_user_o), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
      .r_id_i(r_id_i), .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_last_i(r_last_i),
      .r_user_i(r_user_i), .r_valid_i(r_valid_i), .r_ready_o(r_ready_o)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   rsp_seen = 0;
   int   rsp_exp = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic neg();
      @(negedge clk_i);
   endtask

   task automatic exp_rsp(input logic [31:0] rdata, input logic err);
      sb.push_back('{rdata: rdata, err: err});
      rsp_exp++;
   endtask

   // Every core response is matched against the oldest expectation.
   always @(negedge clk_i) begin
      exp_t e;
      if (rst_ni && data_rvalid_o) begin
         rsp_seen++;
         if (sb.size() == 0) begin
            `CHK("rsp_unexpected", data_rvalid_o, 1'b0);
         end else begin
            e = sb.pop_front();
            checks++;
            if (data_rdata_o !== e.rdata) begin
               errors++;
               $error("FAIL rsp_rdata observed=%0h expected=%0h", data_rdata_o, e.rdata);
            end
            checks++;
            if (data_err_o !== e.err) begin
               errors++;
               $error("FAIL rsp_err observed=%0h expected=%0h", data_err_o, e.err);
            end
         end
      end
   end

   initial begin
      data_req_i = 0; data_we_i = 0; data_addr_i = '0; data_be_i = 4'hF; data_wdata_i = '0;
      aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
      b_id_i = '0; b_resp_i = 2'b00; b_user_i = '0; b_valid_i = 0;
      r_id_i = '0; r_data_i = '0; r_resp_i = 2'b00; r_last_i = 1'b1; r_user_i = '0; r_valid_i = 0;

      repeat (3) step();
      neg();
      `CHK("reset_outputs", {data_gnt_o, data_rvalid_o, data_err_o, ar_valid_o, aw_valid_o,
                              w_valid_o, r_ready_o, b_ready_o}, 8'h00);
      step();
      rst_ni = 1;
      neg();
      `CHK("static_ar", {ar_id_o, ar_len_o, ar_size_o, ar_burst_o, ar_lock_o, ar_cache_o,
                          ar_prot_o, ar_qos_o, ar_region_o, ar_user_o},
           {16'd0, 8'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 10'd0});
      `CHK("static_aw", {aw_id_o, aw_len_o, aw_size_o, aw_burst_o, aw_lock_o, aw_cache_o,
                          aw_prot_o, aw_qos_o, aw_region_o, aw_user_o},
           {16'd0, 8'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 10'd0});
      `CHK("static_w", {w_last_o, w_user_o}, {1'b1, 10'd0});

      // Single read, R beat three cycles after grant.
      step();
      data_req_i = 1; data_we_i = 0; data_addr_i = 32'h100; ar_ready_i = 1;
      neg();
      `CHK("rd1_gnt", {ar_valid_o, data_gnt_o, data_rvalid_o}, 3'b110);
      `CHK("rd1_araddr", ar_addr_o, 32'h100);
      step();
      data_req_i = 0; ar_ready_i = 0;
      neg();
      `CHK("rd1_wait1", {data_gnt_o, ar_valid_o, r_ready_o, b_ready_o, data_rvalid_o}, 5'b00100);
      step();
      neg();
      `CHK("rd1_wait2", data_rvalid_o, 1'b0);
      step();
      r_valid_i = 1; r_data_i = {32'h11111111, 32'hDEADBEEF}; r_resp_i = 2'b00;
      exp_rsp(32'hDEADBEEF, 1'b0);
      neg();
      `CHK("rd1_rvalid", data_rvalid_o, 1'b1);
      step();
      r_valid_i = 0;
      neg();
      `CHK("rd1_drained", {r_ready_o, data_rvalid_o}, 2'b00);

      // Four back-to-back reads fill the tracker; the fifth waits for a response.
      for (int i = 0; i < 4; i++) begin
         step();
         data_req_i = 1; data_we_i = 0; data_addr_i = 32'h200 + 32'(4 * i); ar_ready_i = 1;
         neg();
         `CHK("b2b_gnt", data_gnt_o, 1'b1);
         `CHK("b2b_araddr", ar_addr_o, 32'h200 + 32'(4 * i));
      end
      step();
      data_addr_i = 32'h210;
      neg();
      `CHK("full_stall1", {data_gnt_o, ar_valid_o}, 2'b00);
      step();
      neg();
      `CHK("full_stall2", {data_gnt_o, ar_valid_o}, 2'b00);
      step();
      r_valid_i = 1; r_data_i = {32'hB0000000, 32'hA0000000}; r_resp_i = 2'b00;
      exp_rsp(32'hA0000000, 1'b0);
      neg();
      `CHK("full_gnt_on_rsp", {data_gnt_o, ar_valid_o, data_rvalid_o}, 3'b111);
      for (int i = 1; i < 5; i++) begin
         step();
         data_req_i = 0; ar_ready_i = 0;
         r_data_i = {32'hB0000000 + 32'(i), 32'hA0000000 + 32'(i)};
         r_resp_i = (i == 2) ? 2'b11 : 2'b00;
         exp_rsp((i % 2 == 1) ? 32'hB0000000 + 32'(i) : 32'hA0000000 + 32'(i), i == 2);
         neg();
         `CHK("b2b_rvalid", data_rvalid_o, 1'b1);
      end
      step();
      r_valid_i = 0; r_resp_i = 2'b00;
      neg();
      `CHK("b2b_drained", r_ready_o, 1'b0);

      // Write with AW accepted at once and W two cycles later; SLVERR response.
      step();
      data_req_i = 1; data_we_i = 1; data_addr_i = 32'h300; data_be_i = 4'hF;
      data_wdata_i = 32'hCAFEF00D; aw_ready_i = 1; w_ready_i = 0;
      neg();
      `CHK("wr_c0_valids", {aw_valid_o, w_valid_o, data_gnt_o, ar_valid_o}, 4'b1100);
      `CHK("wr_c0_wdata", w_data_o, {32'hCAFEF00D, 32'hCAFEF00D});
      `CHK("wr_c0_wstrb", w_strb_o, 8'h0F);
      `CHK("wr_c0_awaddr", aw_addr_o, 32'h300);
      step();
      aw_ready_i = 0;
      neg();
      `CHK("wr_c1_valids", {aw_valid_o, w_valid_o, data_gnt_o}, 3'b010);
      step();
      w_ready_i = 1;
      neg();
      `CHK("wr_c2_gnt", {aw_valid_o, w_valid_o, data_gnt_o}, 3'b011);
      step();
      data_req_i = 0; w_ready_i = 0;
      neg();
      `CHK("wr_c3_ready", {w_valid_o, b_ready_o, r_ready_o}, 3'b010);
      step();
      b_valid_i = 1; b_resp_i = 2'b10;
      exp_rsp(32'd0, 1'b1);
      neg();
      `CHK("wr_b_rvalid", data_rvalid_o, 1'b1);
      step();
      b_valid_i = 0; b_resp_i = 2'b00;
      neg();
      `CHK("wr_drained", b_ready_o, 1'b0);

      // Upper-lane write strobes and read data selection.
      step();
      data_req_i = 1; data_we_i = 1; data_addr_i = 32'h1004; data_be_i = 4'b0011;
      data_wdata_i = 32'h5555AAAA; aw_ready_i = 1; w_ready_i = 1;
      neg();
      `CHK("lane_wstrb", w_strb_o, 8'h30);
      `CHK("lane_wdata", w_data_o, {32'h5555AAAA, 32'h5555AAAA});
      `CHK("lane_wr_gnt", data_gnt_o, 1'b1);
      step();
      data_req_i = 0; aw_ready_i = 0; w_ready_i = 0; b_valid_i = 1; b_resp_i = 2'b00;
      exp_rsp(32'd0, 1'b0);
      neg();
      `CHK("lane_b_rvalid", data_rvalid_o, 1'b1);
      step();
      b_valid_i = 0;
      data_req_i = 1; data_we_i = 0; data_addr_i = 32'h1004; data_be_i = 4'hF; ar_ready_i = 1;
      neg();
      `CHK("lane_rd_gnt", data_gnt_o, 1'b1);
      step();
      data_req_i = 0; ar_ready_i = 0;
      r_valid_i = 1; r_data_i = {32'h12345678, 32'h9ABCDEF0};
      exp_rsp(32'h12345678, 1'b0);
      neg();
      `CHK("lane_rd_rvalid", data_rvalid_o, 1'b1);
      step();
      r_valid_i = 0;

      // A write behind an outstanding read waits for the read to drain.
      data_req_i = 1; data_we_i = 0; data_addr_i = 32'h400; ar_ready_i = 1;
      neg();
      `CHK("dir_rd_gnt", data_gnt_o, 1'b1);
      step();
      data_we_i = 1; data_addr_i = 32'h500; data_wdata_i = 32'h0BADF00D;
      ar_ready_i = 0; aw_ready_i = 1; w_ready_i = 1;
      neg();
      `CHK("dir_stall1", {aw_valid_o, w_valid_o, data_gnt_o, ar_valid_o}, 4'b0000);
      step();
      neg();
      `CHK("dir_stall2", {aw_valid_o, w_valid_o, data_gnt_o, ar_valid_o}, 4'b0000);
      step();
      r_valid_i = 1; r_data_i = {32'h0, 32'h44440000};
      exp_rsp(32'h44440000, 1'b0);
      neg();
      `CHK("dir_stall_on_rsp", {aw_valid_o, data_gnt_o, data_rvalid_o}, 3'b001);
      step();
      r_valid_i = 0;
      neg();
      `CHK("dir_wr_gnt", {aw_valid_o, w_valid_o, data_gnt_o}, 3'b111);
      step();
      data_req_i = 0; aw_ready_i = 0; w_ready_i = 0; b_valid_i = 1; b_resp_i = 2'b01;
      exp_rsp(32'd0, 1'b0);
      neg();
      `CHK("dir_b_rvalid", data_rvalid_o, 1'b1);
      step();
      b_valid_i = 0; b_resp_i = 2'b00;

      // Reset with two reads in flight abandons them.
      data_req_i = 1; data_we_i = 0; data_addr_i = 32'h600; ar_ready_i = 1;
      neg();
      `CHK("rst_rd0_gnt", data_gnt_o, 1'b1);
      step();
      data_addr_i = 32'h608;
      neg();
      `CHK("rst_rd1_gnt", data_gnt_o, 1'b1);
      step();
      data_req_i = 0; ar_ready_i = 0; rst_ni = 0;
      step();
      rst_ni = 1;
      neg();
      `CHK("post_reset", {data_gnt_o, data_rvalid_o, ar_valid_o, aw_valid_o, w_valid_o,
                          r_ready_o, b_ready_o}, 7'b0);
      step();
      r_valid_i = 1; r_data_i = 64'hFFFF; b_valid_i = 1; b_resp_i = 2'b10;
      neg();
      `CHK("stray_ignored", {r_ready_o, b_ready_o, data_rvalid_o, data_err_o}, 4'b0000);
      step();
      r_valid_i = 0; b_valid_i = 0; b_resp_i = 2'b00;
      data_req_i = 1; data_we_i = 0; data_addr_i = 32'h700; ar_ready_i = 1;
      neg();
      `CHK("post_rst_gnt", data_gnt_o, 1'b1);
      `CHK("post_rst_araddr", ar_addr_o, 32'h700);
      step();
      data_req_i = 0; ar_ready_i = 0; r_valid_i = 1; r_data_i = {32'h0, 32'h77770000};
      exp_rsp(32'h77770000, 1'b0);
      neg();
      `CHK("post_rst_rvalid", data_rvalid_o, 1'b1);
      step();
      r_valid_i = 0;
      neg();
      `CHK("post_rst_drained", r_ready_o, 1'b0);
      step();

      `CHK("sb_empty", sb.size(), 0);
      `CHK("rsp_count", rsp_seen, rsp_exp);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
